// File: rtl/click_counter.sv
// rtl/click_counter.sv - debounced two-button BCD click counter with 4-digit display scan
module click_counter #(
  parameter int DB_CNT   = 500000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_clr,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic [15:0] count_bcd,
  output logic        ovf
);

  localparam int DB_W = $clog2(DB_CNT + 1);
  localparam int SC_W = $clog2(SCAN_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

  // Per-button vectors: bit 0 is the increment button, bit 1 the clear button.
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      sync_fill;
  logic [1:0]      db_lvl;
  logic [1:0]      db_lvl_d;
  logic [1:0]      armed;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];
  logic            inc_ev;
  logic            clr_ev;

  logic [15:0]     count_next;
  logic            carry;

  logic [SC_W-1:0] presc;
  logic [1:0]      digit_idx;
  logic [1:0]      num_idx;
  logic            an_vld;

  // Two-flop synchronizers; sync_fill marks when sync_b holds a real post-reset sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a    <= 2'b00;
      sync_b    <= 2'b00;
      sync_fill <= 2'b00;
    end else begin
      sync_a    <= {btn_clr, btn_inc};
      sync_b    <= sync_a;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Independent debounce counters: flip the level after DB_CNT consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_lvl <= 2'b00;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_b[b] != db_lvl[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            db_lvl[b] <= ~db_lvl[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + DB_ONE;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // A button only produces presses once it has been seen released after reset,
  // so a level held through reset can never count as a fresh press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed    <= 2'b00;
      db_lvl_d <= 2'b00;
    end else begin
      armed    <= armed | ({2{sync_fill[1]}} & ~sync_b);
      db_lvl_d <= db_lvl;
    end
  end

  assign press  = db_lvl & ~db_lvl_d & armed;
  assign inc_ev = press[0];
  assign clr_ev = press[1];

  // Decimal ripple increment; a nibble at 9 (or any stray value above) rolls to 0 and carries.
  always_comb begin
    count_next = count_bcd;
    carry      = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (count_bcd[d*4 +: 4] >= 4'd9) begin
          count_next[d*4 +: 4] = 4'd0;
        end else begin
          count_next[d*4 +: 4] = count_bcd[d*4 +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  // Count register: clear wins over increment; ovf pulses only on the 9999 -> 0000 wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_bcd <= 16'h0000;
      ovf       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (clr_ev) begin
        count_bcd <= 16'h0000;
      end else if (inc_ev) begin
        count_bcd <= count_next;
        ovf       <= carry;
      end
    end
  end

  // Free-running scan prescaler; the digit index steps on each prescaler wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc     <= '0;
      digit_idx <= 2'd0;
    end else if (presc == SC_LAST) begin
      presc     <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      presc     <= presc + SC_ONE;
    end
  end

  // Display pipeline: num follows the live count, an trails num by one cycle to match the decoder.
  always_ff @(posedge clk) begin
    if (!rst) begin
      num     <= 4'd0;
      num_idx <= 2'd0;
      an_vld  <= 1'b0;
      an      <= 4'b1111;
    end else begin
      num     <= count_bcd[{digit_idx, 2'b00} +: 4];
      num_idx <= digit_idx;
      an_vld  <= 1'b1;
      an      <= an_vld ? ~(4'b0001 << num_idx) : 4'b1111;
    end
  end

endmodule

// File: doc/click_counter.md
CLICK_COUNTER -- requirements
Module: click_counter

Interface
REQ-001 SHALL have parameter DB_CNT, default 500000, meaning the number of consecutive cycles a raw button level must hold before the debounced level changes.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per display digit slot (SCAN_DIV >= 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low; rst=0 at a posedge clk resets the block.
REQ-005 SHALL have port btn_inc, input, 1 bit: raw increment button, active-high, asynchronous to clk, bouncing.
REQ-006 SHALL have port btn_clr, input, 1 bit: raw clear button, active-high, asynchronous to clk, bouncing.
REQ-007 SHALL have port num, output, 4 bits: BCD digit currently scanned, registered, feeding the 7-segment decoder.
REQ-008 SHALL have port an, output, 4 bits: digit anode enables, active-low, one-hot-zero, registered.
REQ-009 SHALL have port count_bcd, output, 16 bits: full count as four BCD nibbles, [15:12] thousands ... [3:0] units.
REQ-010 SHALL have port ovf, output, 1 bit: single-cycle pulse on wrap 9999->0000.

Function
REQ-011 SHALL pass each button through a two-flop synchronizer before any other logic.
REQ-012 SHALL debounce each synchronized button independently: a per-button counter increments while the synchronized level differs from the debounced level, clears to 0 whenever they agree, and on reaching DB_CNT flips the debounced level and clears.
REQ-013 SHALL generate a one-cycle press event on each 0->1 transition of a debounced level; releases generate no event.
REQ-014 SHALL, on an inc event, increment count_bcd by one in decimal: units 9 -> 0 with carry into tens, likewise up through thousands; count_bcd changes in the cycle after the event.
REQ-015 SHALL, on an inc event at count 9999, load 0000 and assert ovf for exactly that cycle; ovf SHALL be 0 otherwise.
REQ-016 SHALL, on a clr event, load count_bcd = 0000 and not assert ovf.
REQ-017 SHALL give clr priority when inc and clr events occur in the same cycle: result 0000, ovf=0.
REQ-018 SHALL never hold a nibble value above 9 in count_bcd.
REQ-019 SHALL run a prescaler 0..SCAN_DIV-1, free-running and wrapping to 0; on the wrap cycle the digit index advances 0->1->2->3->0.
REQ-020 SHALL register num = count_bcd nibble selected by the digit index (index 0 = [3:0], index 3 = [15:12]), so num reflects the index and count from the previous cycle.
REQ-021 SHALL register an one cycle after num, so each an change lands in the same cycle as the registered segment decoder's output for that num: an[i]=0 exactly for the digit index i whose nibble num carried one cycle earlier.
REQ-022 SHALL update num within the current slot when count_bcd changes, with no wait for the next slot.

Reset
REQ-023 SHALL, when rst=0 at posedge clk, clear synchronizers, debounce counters, debounced levels (0), count_bcd (0000), prescaler (0), digit index (0), num (0), ovf (0), and set an = 4'b1111 (all digits off).
REQ-024 SHALL discard a reset asserted mid-debounce or mid-scan entirely: no press event is produced from a level held across reset unless it is re-qualified for DB_CNT cycles after release.
REQ-025 SHALL drive an = 4'b1110 two cycles after rst is released, with num = count_bcd[3:0] from one cycle after release.

Verification (DB_CNT=4, SCAN_DIV=3)
REQ-026 SHALL pass: btn_inc high for 10 cycles with 1-cycle glitches every 3 cycles -> no increment; clean hold for >= 6 cycles -> count_bcd 0000->0001 exactly once.
REQ-027 SHALL pass: 12 clean inc presses from reset -> count_bcd = 0x0012; press at 0x0099 -> 0x0100.
REQ-028 SHALL pass: preload to 9999 by presses, one more press -> count_bcd = 0x0000, ovf high for exactly one cycle.
REQ-029 SHALL pass: inc and clr debounced in the same cycle at count 0x0042 -> 0x0000, ovf=0.
REQ-030 SHALL pass: count 0x1234, observe 12+ cycles -> num sequence 4,3,2,1 repeating, each held 3 cycles, with an = 1110,1101,1011,0111 each lagging num by exactly one cycle.
REQ-031 SHALL pass: rst=0 for one cycle mid-scan with count 0x0567 and btn_inc held high -> all outputs at reset values next cycle; no increment until btn_inc is seen low and then high for DB_CNT cycles.
